// File: rtl/note_player_pkg.sv
// Shared widths, square amplitude and FSM state encoding for the note player.
// Optional square-wave output is enabled by defining NOTE_PLAYER_SQUARE_EN.
package note_player_pkg;
    localparam int NOTE_W      = 6;
    localparam int DUR_W       = 6;
    localparam int STEP_INT_W  = 10;
    localparam int STEP_FRAC_W = 10;
    localparam int STEP_W      = STEP_INT_W + STEP_FRAC_W;
    localparam int PHASE_W     = 23;
    localparam int PHASE_INT_W = PHASE_W - STEP_FRAC_W;

    localparam logic signed [15:0] SQ_AMP = 16'sd8192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;
endpackage

// File: rtl/note_player_if.sv
// Sequencer-facing note request / completion and sample-output bundle.
// Handshake: a load_new_note pulse is accepted only while busy is low; busy acts as
// the inverse of ready and stays high until the done_with_note pulse.
interface note_player_if;
    logic [note_player_pkg::NOTE_W-1:0]      note;
    logic [note_player_pkg::DUR_W-1:0]       duration;
    logic                                    load_new_note;
    logic                                    busy;
    logic                                    done_with_note;
    logic                                    sample_valid;
    logic [note_player_pkg::PHASE_INT_W-1:0] sample_phase;

    modport master (
        output note, duration, load_new_note,
        input  busy, done_with_note, sample_valid, sample_phase
    );

    modport slave (
        input  note, duration, load_new_note,
        output busy, done_with_note, sample_valid, sample_phase
    );
endinterface

// File: rtl/note_player_phase_accum.sv
// Phase step register plus wrapping phase accumulator (13 integer + 10 fraction bits).
// With NOTE_PLAYER_SQUARE_EN it also reports whether the latched step is a rest.
module note_player_phase_accum
    import note_player_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_step,
    input  logic [STEP_W-1:0]  step_in,
    input  logic               clear,
    input  logic               advance,
`ifdef NOTE_PLAYER_SQUARE_EN
    output logic               step_zero,
`endif
    output logic [PHASE_W-1:0] phase_next
);
    logic [STEP_W-1:0]  step;
    logic [PHASE_W-1:0] phase;

    // Wrap modulo 2^23 falls out of the fixed accumulator width.
    assign phase_next = phase + {{(PHASE_W-STEP_W){1'b0}}, step};

`ifdef NOTE_PLAYER_SQUARE_EN
    assign step_zero = (step == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= '0;
            phase <= '0;
        end else begin
            if (load_step) step <= step_in;
            if (clear)        phase <= '0;
            else if (advance) phase <= phase_next;
        end
    end
endmodule

// File: rtl/note_player.sv
// Fetches a note's phase step from the frequency ROM, then advances the phase per
// sample strobe and counts beats until the note ends. NOTE_PLAYER_SQUARE_EN adds square_out.
module note_player
    import note_player_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     play_enable,
    input  logic                     beat,
    input  logic                     generate_next_sample,
    output logic [NOTE_W-1:0]        rom_addr,
    input  logic [STEP_W-1:0]        rom_data,
    note_player_if.slave             pif,
`ifdef NOTE_PLAYER_SQUARE_EN
    output logic signed [15:0]       square_out,
`endif
    output state_t                   dbg_state
);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    state_t             state;
    logic [DUR_W-1:0]   dur_reg;
    logic [DUR_W-1:0]   remaining;
    logic [PHASE_W-1:0] phase_next;
    logic               in_latch;
    logic               advance;

    assign dbg_state = state;
    assign in_latch  = (state == ST_LATCH);
    // A note with zero beats left ends without taking its sample.
    assign advance   = (state == ST_PLAY) && play_enable && (remaining != '0) && generate_next_sample;

`ifdef NOTE_PLAYER_SQUARE_EN
    logic step_zero;
`endif

    note_player_phase_accum u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_step  (in_latch),
        .step_in    (rom_data),
        .clear      (in_latch),
        .advance    (advance),
`ifdef NOTE_PLAYER_SQUARE_EN
        .step_zero  (step_zero),
`endif
        .phase_next (phase_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            rom_addr           <= '0;
            dur_reg            <= '0;
            remaining          <= '0;
            pif.busy           <= 1'b0;
            pif.done_with_note <= 1'b0;
            pif.sample_valid   <= 1'b0;
            pif.sample_phase   <= '0;
        end else begin
            pif.done_with_note <= 1'b0;
            pif.sample_valid   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pif.load_new_note) begin
                        rom_addr <= pif.note;
                        dur_reg  <= pif.duration;
                        pif.busy <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    remaining <= dur_reg;
                    state     <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (play_enable) begin
                        if (remaining == '0) begin
                            pif.done_with_note <= 1'b1;
                            pif.busy           <= 1'b0;
                            state              <= ST_IDLE;
                        end else begin
                            if (generate_next_sample) begin
                                pif.sample_valid <= 1'b1;
                                pif.sample_phase <= phase_next[PHASE_W-1 -: PHASE_INT_W];
                            end
                            if (beat) begin
                                remaining <= remaining - DUR_ONE;
                                if (remaining == DUR_ONE) begin
                                    pif.done_with_note <= 1'b1;
                                    pif.busy           <= 1'b0;
                                    state              <= ST_IDLE;
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NOTE_PLAYER_SQUARE_EN
    // Value travels with its sample_valid pulse, then returns to 0 once out of PLAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            square_out <= '0;
        end else if (advance) begin
            if (step_zero)                 square_out <= '0;
            else if (phase_next[PHASE_W-1]) square_out <= -SQ_AMP;
            else                           square_out <= SQ_AMP;
        end else if (state != ST_PLAY) begin
            square_out <= '0;
        end
    end
`endif
endmodule
